// File: rtl/tilemap_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tilemap_fetch_ctrl
//
// Per-scanline tilemap fetch sequencer. A line_start strobe launches a walk
// over the tile columns of the requested pixel row. For every column the
// block presents row/col to the external tilemap address decoder, requests
// the shared video RAM for the tile code and color, reads the tile ROM slice
// for the row, and writes one 8-pixel entry into the line buffer.
//
// Ports
//   clk, rst_L              system clock, async active-low reset
//   line_start, line_row    fetch strobe and the pixel row it refers to
//   busy, line_done         sequencer activity / one-cycle completion pulse
//   overrun                 sticky: line_start seen while a line was in flight
//   dcd_row, dcd_col        row/col to the address decoder
//   dcd_addr                decoder result (combinational from dcd_row/col)
//   vram_req/addr/gnt       video RAM request handshake shared with the CPU
//   vram_code, vram_color   read data, valid the cycle after the grant
//   rom_addr, rom_data      tile ROM address and the row slice one cycle later
//   lb_we, lb_addr, lb_data line buffer write port
//
// State table
//   state   | meaning
//   IDLE    | waiting for line_start
//   REQ     | video RAM requested for the current tile, waiting for grant
//   VWAIT   | grant taken; code/color arrive at the end of this cycle
//   ROM     | tile ROM address presented
//   WR      | ROM slice valid; line buffer entry written
//   DONE    | line complete, line_done pulsed
// ---------------------------------------------------------------------------
module tilemap_fetch_ctrl #(
    parameter int NUM_TILES = 28,
    parameter int NUM_ROWS  = 288
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic        line_start,
    input  logic [8:0]  line_row,
    output logic        busy,
    output logic        line_done,
    output logic        overrun,
    output logic [8:0]  dcd_row,
    output logic [9:0]  dcd_col,
    input  logic [15:0] dcd_addr,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    input  logic        vram_gnt,
    input  logic [7:0]  vram_code,
    input  logic [7:0]  vram_color,
    output logic [10:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic        lb_we,
    output logic [4:0]  lb_addr,
    output logic [21:0] lb_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_VWAIT = 3'd2,
        S_ROM   = 3'd3,
        S_WR    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [8:0] ROW_LIMIT = 9'(NUM_ROWS);
    localparam logic [4:0] LAST_TILE = 5'(NUM_TILES - 1);

    state_t      state_q;
    logic [8:0]  row_q;
    logic [4:0]  tile_q;
    logic [4:0]  tile_d;
    logic [5:0]  color_q;
    logic        busy_q;
    logic        done_q;
    logic        overrun_q;
    logic        req_q;
    logic [10:0] rom_addr_q;
    logic        we_q;
    logic [4:0]  lb_addr_q;
    logic        in_flight_d;

    // Only the low six color bits reach the line buffer.
    logic        unused_color_bits;
    assign unused_color_bits = ^vram_color[7:6];

    assign tile_d      = tile_q + 5'd1;
    assign in_flight_d = (state_q == S_REQ) || (state_q == S_VWAIT) ||
                         (state_q == S_ROM) || (state_q == S_WR);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            tile_q     <= '0;
            color_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            req_q      <= 1'b0;
            rom_addr_q <= '0;
            we_q       <= 1'b0;
            lb_addr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;

            // A strobe during an active fetch is dropped but remembered.
            if (line_start && in_flight_d) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                // DONE accepts a new line exactly like IDLE, giving
                // back-to-back lines with no idle gap.
                S_IDLE, S_DONE: begin
                    if (line_start) begin
                        row_q  <= line_row;
                        tile_q <= '0;
                        busy_q <= 1'b1;
                        if (line_row < ROW_LIMIT) begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                S_REQ: begin
                    if (vram_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_VWAIT;
                    end
                end

                S_VWAIT: begin
                    color_q    <= vram_color[5:0];
                    rom_addr_q <= {vram_code, row_q[2:0]};
                    state_q    <= S_ROM;
                end

                S_ROM: begin
                    rom_addr_q <= '0;
                    we_q       <= 1'b1;
                    lb_addr_q  <= tile_q;
                    state_q    <= S_WR;
                end

                S_WR: begin
                    lb_addr_q <= '0;
                    if (tile_q == LAST_TILE) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        tile_q  <= tile_d;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign line_done = done_q;
    assign overrun   = overrun_q;
    assign dcd_row   = row_q;
    assign dcd_col   = {2'b00, tile_q, 3'b000};
    assign vram_req  = req_q;
    assign rom_addr  = rom_addr_q;
    assign lb_we     = we_q;
    assign lb_addr   = lb_addr_q;

    // dcd_row/dcd_col are held for the whole REQ state, so the decoder
    // output is stable while the request is pending.
    assign vram_addr = req_q ? dcd_addr : 16'h0000;

    // The ROM slice only becomes valid during WR, so the line buffer data
    // is assembled combinationally in that cycle.
    assign lb_data   = we_q ? {color_q, rom_data} : 22'h000000;

endmodule

// File: tb/tb_tilemap_fetch_ctrl.sv
module tb_tilemap_fetch_ctrl;

    logic        clk;
    logic        rst_L;
    logic        line_start;
    logic [8:0]  line_row;
    logic        busy;
    logic        line_done;
    logic        overrun;
    logic [8:0]  dcd_row;
    logic [9:0]  dcd_col;
    logic [15:0] dcd_addr;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_gnt;
    logic [7:0]  vram_code;
    logic [7:0]  vram_color;
    logic [10:0] rom_addr;
    logic [15:0] rom_data;
    logic        lb_we;
    logic [4:0]  lb_addr;
    logic [21:0] lb_data;

    logic code_mode;   // 0: code = tile index, color 0x15; 1: address-derived
    logic rom_const;   // 1: ROM returns 0xA5A5; 0: address-derived

    int n_vec;
    int n_err;

    tilemap_fetch_ctrl dut (
        .clk        (clk),
        .rst_L      (rst_L),
        .line_start (line_start),
        .line_row   (line_row),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun),
        .dcd_row    (dcd_row),
        .dcd_col    (dcd_col),
        .dcd_addr   (dcd_addr),
        .vram_req   (vram_req),
        .vram_addr  (vram_addr),
        .vram_gnt   (vram_gnt),
        .vram_code  (vram_code),
        .vram_color (vram_color),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .lb_we      (lb_we),
        .lb_addr    (lb_addr),
        .lb_data    (lb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tilemap decoder: 28x36 tile map, columns mirrored, middle rows stored
    // column-major, two top and two bottom rows in their own strips.
    function automatic logic [15:0] decode(input logic [8:0] row, input logic [9:0] col);
        int r;
        int c;
        int a;
        r = int'(row) / 8;
        c = int'(col) / 8;
        if (r == 0)       a = 'h3C2 + 27 - c;
        else if (r == 1)  a = 'h3E2 + 27 - c;
        else if (r == 34) a = 'h002 + 27 - c;
        else if (r == 35) a = 'h022 + 27 - c;
        else              a = 'h040 + (27 - c) * 32 + (r - 2);
        return 16'(a);
    endfunction

    function automatic logic [7:0] code_f(input logic [15:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] color_f(input logic [15:0] a);
        return {2'b11, a[5:0] ^ 6'h2A};
    endfunction

    function automatic logic [15:0] rom_f(input logic [10:0] a);
        return {a, a[10:6]} ^ 16'h0F0F;
    endfunction

    // Expected line-buffer word with the address-derived memory models.
    function automatic logic [21:0] exp_lb(input logic [8:0] row, input int t);
        logic [15:0] a;
        logic [7:0]  c;
        logic [7:0]  col;
        a   = decode(row, 10'(t * 8));
        c   = code_f(a);
        col = color_f(a);
        return {col[5:0], rom_f({c, row[2:0]})};
    endfunction

    assign dcd_addr = decode(dcd_row, dcd_col);

    always @(posedge clk) begin
        if (vram_req && vram_gnt) begin
            if (code_mode) begin
                vram_code  <= code_f(vram_addr);
                vram_color <= color_f(vram_addr);
            end else begin
                vram_code  <= {3'b000, dcd_col[7:3]};
                vram_color <= 8'h15;
            end
        end else begin
            vram_code  <= 8'hEE;
            vram_color <= 8'hEE;
        end
        rom_data <= rom_const ? 16'hA5A5 : rom_f(rom_addr);
    end

    task automatic test_reset;
        rst_L = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_vec++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", vram_req); end
        n_vec++; if ({overrun, line_done, lb_we} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {overrun, line_done, lb_we}); end
        n_vec++; if ({dcd_row, dcd_col, rom_addr, lb_addr} !== 35'd0) begin n_err++; $display("FAIL reset_regs: got row=%0d col=%0d rom=%h lba=%0d want all 0", dcd_row, dcd_col, rom_addr, lb_addr); end
        n_vec++; if (lb_data !== 22'd0) begin n_err++; $display("FAIL reset_lbdata: got %h want 0", lb_data); end
        rst_L = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: got busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_midline;
        code_mode = 1'b0; rom_const = 1'b1; vram_gnt = 1'b1;
        @(negedge clk); line_row = 9'd8; line_start = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            line_start = (k == 6);
        end
        n_vec++; if (vram_req !== 1'b1 || dcd_col !== 10'd40) begin n_err++; $display("FAIL midline_tile5: got req=%0b col=%0d want 1/40", vram_req, dcd_col); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL midline_overrun: got %0b want 1", overrun); end
        #2 rst_L = 1'b0;
        #1;
        n_vec++; if (vram_req !== 1'b0) begin n_err++; $display("FAIL async_req: got %0b want 0", vram_req); end
        n_vec++; if (busy !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL async_state: got busy=%0b ovr=%0b want 0/0", busy, overrun); end
        n_vec++; if (dcd_col !== 10'd0 || dcd_row !== 9'd0) begin n_err++; $display("FAIL async_regs: got row=%0d col=%0d want 0/0", dcd_row, dcd_col); end
        @(negedge clk); rst_L = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || vram_req !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got busy=%0b req=%0b want 0/0", busy, vram_req); end
    endtask

    task automatic test_full_line;
        int wr = 0;
        int done_k = -1;
        int n_done = 0;
        int bad_busy = 0;
        int bad_req = 0;
        int bad_rom = 0;
        int bad_wr = 0;
        code_mode = 1'b0; rom_const = 1'b1; vram_gnt = 1'b1;
        @(negedge clk); line_row = 9'd8; line_start = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            line_start = 1'b0;
            if (busy !== (k <= 113)) bad_busy++;
            if (vram_req !== ((k % 4 == 1) && k <= 109)) bad_req++;
            if (k % 4 == 3 && k <= 111) begin
                if (rom_addr !== {8'((k - 3) / 4), 3'b000}) bad_rom++;
            end else if (rom_addr !== 11'd0) bad_rom++;
            if (lb_we) begin
                if (k != 4 * wr + 4 || lb_addr !== 5'(wr) || lb_data !== 22'h15A5A5) bad_wr++;
                wr++;
            end else if (lb_data !== 22'd0 || lb_addr !== 5'd0) bad_wr++;
            if (line_done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (k == 41) begin
                n_vec++; if (dcd_col !== 10'd80) begin n_err++; $display("FAIL full_dcdcol10: got %0d want 80", dcd_col); end
                n_vec++; if (vram_addr !== 16'h03F3) begin n_err++; $display("FAIL full_vaddr10: got %h want 03f3", vram_addr); end
            end
            if (k == 43) begin
                n_vec++; if (rom_addr !== 11'h050) begin n_err++; $display("FAIL full_romaddr10: got %h want 050", rom_addr); end
            end
        end
        n_vec++; if (wr != 28) begin n_err++; $display("FAIL full_writes: got %0d want 28", wr); end
        n_vec++; if (bad_wr != 0) begin n_err++; $display("FAIL full_wrdata: got %0d bad writes want 0", bad_wr); end
        n_vec++; if (done_k != 113 || n_done != 1) begin n_err++; $display("FAIL full_done: got cycle %0d count %0d want 113/1", done_k, n_done); end
        n_vec++; if (bad_busy != 0) begin n_err++; $display("FAIL full_busy: got %0d bad cycles want 0", bad_busy); end
        n_vec++; if (bad_req != 0) begin n_err++; $display("FAIL full_req: got %0d bad cycles want 0", bad_req); end
        n_vec++; if (bad_rom != 0) begin n_err++; $display("FAIL full_rom: got %0d bad cycles want 0", bad_rom); end
    endtask

    task automatic test_grant_stall;
        int wr = 0;
        int done_k = -1;
        int bad_busy = 0;
        int bad_hold = 0;
        int bad_wr = 0;
        int exp_k;
        code_mode = 1'b1; rom_const = 1'b0; vram_gnt = 1'b1;
        @(negedge clk); line_row = 9'd272; line_start = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            @(negedge clk);
            line_start = 1'b0;
            vram_gnt = !(k >= 33 && k <= 37);
            if (busy !== (k <= 118)) bad_busy++;
            if (k >= 33 && k <= 38) begin
                if (vram_req !== 1'b1 || vram_addr !== 16'h0015 || dcd_col !== 10'd64) bad_hold++;
            end
            if (lb_we) begin
                exp_k = 4 * wr + 4 + ((wr >= 8) ? 5 : 0);
                if (k != exp_k || lb_addr !== 5'(wr) || lb_data !== exp_lb(9'd272, wr)) bad_wr++;
                wr++;
            end
            if (line_done && done_k < 0) done_k = k;
        end
        vram_gnt = 1'b1;
        n_vec++; if (bad_hold != 0) begin n_err++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad_hold); end
        n_vec++; if (wr != 28 || bad_wr != 0) begin n_err++; $display("FAIL stall_writes: got %0d writes %0d bad want 28/0", wr, bad_wr); end
        n_vec++; if (done_k != 118) begin n_err++; $display("FAIL stall_done: got cycle %0d want 118", done_k); end
        n_vec++; if (bad_busy != 0) begin n_err++; $display("FAIL stall_busy: got %0d bad cycles want 0", bad_busy); end
    endtask

    task automatic test_blanking;
        int bad = 0;
        @(negedge clk); line_row = 9'd300; line_start = 1'b1;
        @(negedge clk); line_start = 1'b0;
        n_vec++; if (line_done !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL blank_cycle1: got done=%0b busy=%0b want 1/1", line_done, busy); end
        n_vec++; if (vram_req !== 1'b0 || lb_we !== 1'b0) begin n_err++; $display("FAIL blank_quiet1: got req=%0b we=%0b want 0/0", vram_req, lb_we); end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (busy || line_done || vram_req || lb_we || rom_addr != 11'd0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL blank_after: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_row_boundary;
        int wr = 0;
        int done_k = -1;
        int bad = 0;
        logic [10:0] exp_ra;
        exp_ra = {code_f(decode(9'd287, 10'd0)), 3'd7};
        code_mode = 1'b1; rom_const = 1'b0; vram_gnt = 1'b1;
        @(negedge clk); line_row = 9'd288; line_start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_vec++; if (line_done !== 1'b1 || vram_req !== 1'b0) begin n_err++; $display("FAIL row288_blank: got done=%0b req=%0b want 1/0", line_done, vram_req); end
            end
            if (k == 2) begin
                n_vec++; if (vram_req !== 1'b1 || dcd_row !== 9'd287 || line_done !== 1'b0) begin n_err++; $display("FAIL row287_b2b: got req=%0b row=%0d done=%0b want 1/287/0", vram_req, dcd_row, line_done); end
            end
            if (k == 4) begin
                n_vec++; if (rom_addr !== exp_ra) begin n_err++; $display("FAIL row287_romaddr: got %h want %h", rom_addr, exp_ra); end
            end
            if (lb_we) begin
                if (k != 4 * wr + 5 || lb_addr !== 5'(wr) || lb_data !== exp_lb(9'd287, wr)) bad++;
                wr++;
            end
            if (line_done && k > 1 && done_k < 0) done_k = k;
            line_start = (k == 1);
            if (k == 1) line_row = 9'd287;
        end
        n_vec++; if (wr != 28 || bad != 0) begin n_err++; $display("FAIL row287_writes: got %0d writes %0d bad want 28/0", wr, bad); end
        n_vec++; if (done_k != 114) begin n_err++; $display("FAIL row287_done: got cycle %0d want 114", done_k); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL done_accept_overrun: got %0b want 0", overrun); end
    endtask

    task automatic test_overrun_back_to_back;
        int wr = 0;
        int bad = 0;
        int exp_k;
        code_mode = 1'b1; rom_const = 1'b0; vram_gnt = 1'b1;
        @(negedge clk); line_row = 9'd280; line_start = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            if (k == 49) begin
                n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_before: got %0b want 0", overrun); end
            end
            if (k == 51) begin
                n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b want 1", overrun); end
            end
            if (k == 69) begin
                n_vec++; if (vram_req !== 1'b1 || vram_addr !== 16'h002C) begin n_err++; $display("FAIL ovr_tile17: got req=%0b addr=%h want 1/002c", vram_req, vram_addr); end
            end
            if (k == 100) begin
                n_vec++; if (dcd_row !== 9'd280) begin n_err++; $display("FAIL ovr_row_kept: got %0d want 280", dcd_row); end
            end
            if (k == 113) begin
                n_vec++; if (line_done !== 1'b1) begin n_err++; $display("FAIL ovr_done1: got %0b want 1", line_done); end
            end
            if (k == 114) begin
                n_vec++; if (vram_req !== 1'b1 || busy !== 1'b1 || dcd_row !== 9'd160 || dcd_col !== 10'd0) begin n_err++; $display("FAIL b2b_start: got req=%0b busy=%0b row=%0d col=%0d want 1/1/160/0", vram_req, busy, dcd_row, dcd_col); end
            end
            if (k == 142) begin
                n_vec++; if (vram_addr !== 16'h02D2) begin n_err++; $display("FAIL b2b_tile7: got %h want 02d2", vram_addr); end
            end
            if (k == 226) begin
                n_vec++; if (line_done !== 1'b1) begin n_err++; $display("FAIL b2b_done: got %0b want 1", line_done); end
            end
            if (k == 227) begin
                n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %0b want 0", busy); end
            end
            if (lb_we) begin
                if (wr < 28) begin
                    exp_k = 4 * wr + 4;
                    if (k != exp_k || lb_addr !== 5'(wr) || lb_data !== exp_lb(9'd280, wr)) bad++;
                end else begin
                    exp_k = 117 + 4 * (wr - 28);
                    if (k != exp_k || lb_addr !== 5'(wr - 28) || lb_data !== exp_lb(9'd160, wr - 28)) bad++;
                end
                wr++;
            end
            line_start = (k == 50) || (k == 113);
            if (k == 50)  line_row = 9'd5;
            if (k == 113) line_row = 9'd160;
        end
        n_vec++; if (wr != 56 || bad != 0) begin n_err++; $display("FAIL ovr_writes: got %0d writes %0d bad want 56/0", wr, bad); end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %0b want 1", overrun); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_L = 1'b0;
        line_start = 1'b0;
        line_row = 9'd0;
        vram_gnt = 1'b0;
        code_mode = 1'b0;
        rom_const = 1'b1;
        test_reset;
        test_reset_midline;
        test_full_line;
        test_grant_stall;
        test_blanking;
        test_row_boundary;
        test_overrun_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
